// File: rtl/fft_pkg.sv
// Shared FFT constants, sample types and the bit-reversal helper used by the
// FFT_32 core, the output serializer and bench models.
package fft_pkg;

  localparam int INT     = 4;
  localparam int DEC     = 4;
  localparam int W       = INT + DEC;
  localparam int NPT     = 32;
  localparam int LOG2NPT = $clog2(NPT);

  typedef logic signed [W-1:0] sample_t;

  typedef struct packed {
    sample_t re;
    sample_t im;
  } cplx_t;

  typedef enum logic {
    IDLE,
    STREAM
  } ser_state_t;

  function automatic logic [LOG2NPT-1:0] bitrev(input logic [LOG2NPT-1:0] k);
    logic [LOG2NPT-1:0] r;
    for (int i = 0; i < LOG2NPT; i++) begin
      r[i] = k[LOG2NPT-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One capture bank of the serializer's ping-pong buffer: whole-frame load,
// per-bin read mux and a full flag that is set on load and cleared on drain.
module fft_frame_bank
  import fft_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               clear,
  input  logic [NPT*W-1:0]   real_in,
  input  logic [NPT*W-1:0]   imag_in,
  input  logic [LOG2NPT-1:0] rd_addr,
  output logic               full,
  output logic [W-1:0]       rd_real,
  output logic [W-1:0]       rd_imag
);

  logic [NPT*W-1:0] real_q;
  logic [NPT*W-1:0] imag_q;

  // The flag alone marks a bank as empty, so sample storage needs no reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      real_q <= real_in;
      imag_q <= imag_in;
    end
  end

  assign rd_real = real_q[rd_addr*W +: W];
  assign rd_imag = imag_q[rd_addr*W +: W];

endmodule

// File: rtl/fft_out_serializer.sv
// Ping-pong frame capture of FFT_32 Xk output, streamed one bin per beat.
// Define FFT_SER_BITREV_EN to read stored bins in bit-reversed order.
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int DCNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NPT*W-1:0]   xk_real,
  input  logic [NPT*W-1:0]   xk_imag,
  input  logic               xk_valid,
  output logic               xk_ready,
  output logic [W-1:0]       s_real,
  output logic [W-1:0]       s_imag,
  output logic [LOG2NPT-1:0] s_index,
  output logic               s_valid,
  output logic               s_last,
  input  logic               s_ready,
  output logic [DCNT_W-1:0]  drop_cnt,
  output logic               overflow
);

  ser_state_t         state;
  ser_state_t         state_next;
  logic               wr_sel;
  logic               rd_sel;
  logic               rd_sel_next;
  logic [1:0]         full;
  logic [1:0]         load;
  logic [1:0]         clear;
  logic               capture;
  logic               drop;
  logic               clear_rd;
  logic               load_out;
  logic               next_sel;
  logic [LOG2NPT-1:0] next_idx;
  logic [LOG2NPT-1:0] rd_addr;
  logic [W-1:0]       bank_real [2];
  logic [W-1:0]       bank_imag [2];

  assign xk_ready = !full[wr_sel];
  assign capture  = xk_valid && xk_ready;
  assign drop     = xk_valid && !xk_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign load[b]  = capture && (wr_sel == 1'(b));
    assign clear[b] = clear_rd && (rd_sel == 1'(b));

    fft_frame_bank u_bank (
      .clk     (clk),
      .rst     (rst),
      .load    (load[b]),
      .clear   (clear[b]),
      .real_in (xk_real),
      .imag_in (xk_imag),
      .rd_addr (rd_addr),
      .full    (full[b]),
      .rd_real (bank_real[b]),
      .rd_imag (bank_imag[b])
    );
  end

`ifdef FFT_SER_BITREV_EN
  assign rd_addr = bitrev(next_idx);
`else
  assign rd_addr = next_idx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rd_sel <= 1'b0;
    end else begin
      state  <= state_next;
      rd_sel <= rd_sel_next;
    end
  end

  // Pick the bank/bin for the next beat; the other bank's bin 0 follows a
  // last beat directly so back-to-back frames stream without a bubble.
  always_comb begin
    state_next  = state;
    rd_sel_next = rd_sel;
    clear_rd    = 1'b0;
    load_out    = 1'b0;
    next_sel    = rd_sel;
    next_idx    = '0;
    case (state)
      IDLE: begin
        if (full[rd_sel]) begin
          state_next = STREAM;
          load_out   = 1'b1;
        end
      end
      STREAM: begin
        if (s_ready) begin
          if (s_index == LOG2NPT'(NPT - 1)) begin
            clear_rd    = 1'b1;
            rd_sel_next = !rd_sel;
            if (full[!rd_sel]) begin
              load_out = 1'b1;
              next_sel = !rd_sel;
            end else begin
              state_next = IDLE;
            end
          end else begin
            load_out = 1'b1;
            next_idx = s_index + LOG2NPT'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_last  <= 1'b0;
      s_index <= '0;
      s_real  <= '0;
      s_imag  <= '0;
    end else begin
      s_valid <= (state_next == STREAM);
      if (load_out) begin
        s_real  <= bank_real[next_sel];
        s_imag  <= bank_imag[next_sel];
        s_index <= next_idx;
        s_last  <= (next_idx == LOG2NPT'(NPT - 1));
      end else if (state_next == IDLE) begin
        s_last <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel   <= 1'b0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (capture) begin
        wr_sel <= !wr_sel;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + DCNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Scoreboard bench for fft_out_serializer: directed frames push expected beats,
// a negedge monitor pops and compares each transferred beat and checks stall hold.
module tb_fft_out_serializer;
  import fft_pkg::*;

  localparam int DCNT_W = 8;

  typedef struct packed {
    logic [W-1:0]       re;
    logic [W-1:0]       im;
    logic [LOG2NPT-1:0] idx;
    logic               last;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [NPT*W-1:0]   xk_real;
  logic [NPT*W-1:0]   xk_imag;
  logic               xk_valid;
  logic               xk_ready;
  logic [W-1:0]       s_real;
  logic [W-1:0]       s_imag;
  logic [LOG2NPT-1:0] s_index;
  logic               s_valid;
  logic               s_last;
  logic               s_ready;
  logic [DCNT_W-1:0]  drop_cnt;
  logic               overflow;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  fft_out_serializer #(.DCNT_W(DCNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .xk_real  (xk_real),
    .xk_imag  (xk_imag),
    .xk_valid (xk_valid),
    .xk_ready (xk_ready),
    .s_real   (s_real),
    .s_imag   (s_imag),
    .s_index  (s_index),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .drop_cnt (drop_cnt),
    .overflow (overflow)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LOG2NPT-1:0] ref_rev(input logic [LOG2NPT-1:0] k);
    logic [LOG2NPT-1:0] r;
    for (int i = 0; i < LOG2NPT; i++) r[LOG2NPT-1-i] = k[i];
    return r;
  endfunction

  function automatic logic [NPT*W-1:0] make_re(input int p);
    logic [NPT*W-1:0] v;
    for (int k = 0; k < NPT; k++) begin
      case (p)
        0:       v[k*W +: W] = W'(k);
        1:       v[k*W +: W] = W'(k * 7 + 3);
        2:       v[k*W +: W] = W'(64 + k);
        3:       v[k*W +: W] = W'(192 ^ k);
        default: v[k*W +: W] = W'(k + p * 11);
      endcase
    end
    return v;
  endfunction

  function automatic logic [NPT*W-1:0] make_im(input int p);
    logic [NPT*W-1:0] v;
    for (int k = 0; k < NPT; k++) begin
      case (p)
        0:       v[k*W +: W] = W'(-k);
        1:       v[k*W +: W] = W'(128 + k);
        2:       v[k*W +: W] = W'(~k);
        3:       v[k*W +: W] = W'(k * 3);
        default: v[k*W +: W] = W'(p - 2 * k);
      endcase
    end
    return v;
  endfunction

  task automatic push_frame(input logic [NPT*W-1:0] re_v, input logic [NPT*W-1:0] im_v);
    beat_t              b;
    logic [LOG2NPT-1:0] m;
    for (int k = 0; k < NPT; k++) begin
`ifdef FFT_SER_BITREV_EN
      m = ref_rev(LOG2NPT'(k));
`else
      m = LOG2NPT'(k);
`endif
      b.re   = re_v[m*W +: W];
      b.im   = im_v[m*W +: W];
      b.idx  = LOG2NPT'(k);
      b.last = (k == NPT - 1);
      exp_q.push_back(b);
    end
  endtask

  // Presents frame pattern p for one cycle; returns just after the sampling edge.
  task automatic apply_stimulus(input int p, input bit capture);
    xk_real  = make_re(p);
    xk_imag  = make_im(p);
    xk_valid = 1'b1;
    if (capture) push_frame(xk_real, xk_imag);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin : monitor
    beat_t got;
    beat_t held;
    beat_t e;
    bit    stalled;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
        continue;
      end
      got = {s_real, s_imag, s_index, s_last};
      if (stalled) check_output("hold", {s_valid, got}, {1'b1, held});
      stalled = 1'b0;
      if (s_valid) begin
        if (!s_ready) begin
          stalled = 1'b1;
          held    = got;
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat: got %0h, expected no beat", got);
        end else begin
          e = exp_q.pop_front();
          check_output($sformatf("beat%0d", e.idx), got, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int n;
    rst      = 1'b1;
    xk_valid = 1'b0;
    xk_real  = '0;
    xk_imag  = '0;
    s_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_xk_ready", xk_ready, 1);
    check_output("rst_s_valid", s_valid, 0);
    check_output("rst_s_last", s_last, 0);
    check_output("rst_s_index", s_index, 0);
    check_output("rst_s_data", {s_real, s_imag}, 0);
    check_output("rst_drop_cnt", drop_cnt, 0);
    check_output("rst_overflow", overflow, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] single frame, latency");
    s_ready = 1'b1;
    apply_stimulus(0, 1'b1);
    xk_valid = 1'b0;
    check_output("lat_capture_edge", s_valid, 0);
    check_output("ready_after_capture", xk_ready, 1);
    @(posedge clk);
    #1;
    check_output("lat_first_beat", {s_valid, s_index}, {1'b1, 5'd0});
    wait_drain("drain_single", 100);
    check_output("idle_after_single", {s_valid, s_last}, 0);

    $display("[TB] backpressure");
    s_ready = 1'b0;
    apply_stimulus(1, 1'b1);
    xk_valid = 1'b0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      s_ready = ~s_ready;
      @(posedge clk);
      #1;
    end
    s_ready = 1'b1;
    wait_drain("drain_backpressure", 10);

    $display("[TB] ping-pong and drop");
    s_ready = 1'b0;
    check_output("pp_ready_f1", xk_ready, 1);
    apply_stimulus(2, 1'b1);
    check_output("pp_ready_f2", xk_ready, 1);
    apply_stimulus(3, 1'b1);
    check_output("pp_ready_f3", xk_ready, 0);
    apply_stimulus(4, 1'b0);
    xk_valid = 1'b0;
    check_output("pp_drop_cnt", drop_cnt, 1);
    check_output("pp_overflow", overflow, 1);
    repeat (3) @(posedge clk);
    #1;
    check_output("pp_stalled_bin0", {s_valid, s_index}, {1'b1, 5'd0});
    s_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("pp_no_gap_cycles", 64'(n), 64'd64);
    check_output("pp_idle_after", s_valid, 0);

    $display("[TB] drop counter saturation");
    s_ready = 1'b0;
    apply_stimulus(5, 1'b1);
    apply_stimulus(6, 1'b1);
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(7, 1'b0);
      if (i == 99) check_output("sat_mid_count", drop_cnt, 101);
    end
    xk_valid = 1'b0;
    check_output("sat_drop_cnt", drop_cnt, 255);
    check_output("sat_overflow", overflow, 1);
    check_output("sat_ready_low", xk_ready, 0);
    s_ready = 1'b1;
    wait_drain("drain_saturation", 200);
    check_output("sat_cnt_held", {overflow, drop_cnt}, {1'b1, 8'd255});

    $display("[TB] asynchronous reset mid-stream");
    apply_stimulus(0, 1'b1);
    xk_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check_output("arst_s_valid", s_valid, 0);
    check_output("arst_xk_ready", xk_ready, 1);
    check_output("arst_drop_cnt", drop_cnt, 0);
    check_output("arst_overflow", overflow, 0);
    check_output("arst_s_index", s_index, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("arst_still_idle", s_valid, 0);

    $display("[TB] order check frame after reset");
    apply_stimulus(0, 1'b1);
    xk_valid = 1'b0;
    wait_drain("drain_after_reset", 100);
    check_output("final_drop_cnt", drop_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
